mul4_seq: RTL and testbench
===========================

# mul4_seq

Sequential 4x4 multiplier controller that time-shares a single `add_sub_4` instance as its only adder. It implements shift-and-add for unsigned operands and a two's-complement variant that subtracts on the final step. It sits beside the existing add/sub datapath in the board top and is driven from switches, with results on LEDs. It adds a start/busy/done handshake and produces an 8-bit product in 4 iteration cycles.

## Interface
Parameters: none; widths are fixed to the 4-bit `add_sub_4` datapath.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `signed_mode`  in  1  0 = unsigned, 1 = two's complement; latched with operands
- `multiplicand`  in  4  operand M; latched on accepted start
- `multiplier`  in  4  operand Q; latched on accepted start
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse; product valid and updated
- `product`  out  8  result; held until the next completion
- `product_zero`  out  1  high when `product` == 0

## Operation
- Internal registers:
  - `acc[3:0]` high half, `q[3:0]` low half / multiplier.
  - `m[3:0]` multiplicand, `sm` latched mode.
  - `cnt[1:0]` iteration counter.
  - `state` in {IDLE, RUN, DONE}.
- One `add_sub_4` instance:
  - `a = acc`.
  - `b = q[0] ? m : 4'b0`.
  - `sub_or_add = sm & (cnt == 3) & q[0]`, where 0 = add and 1 = subtract.
- Accept start (`start` = 1 in IDLE or DONE):
  - `acc <= 0`, `q <= multiplier`, `m <= multiplicand`, `sm <= signed_mode`, `cnt <= 0`.
  - `state <= RUN`.
- RUN, each cycle:
  - `{acc, q} <= {msb_in, result, q[3:1]}`; `cnt <= cnt + 1`.
  - `msb_in` is `carry` in unsigned mode and `result[3] ^ overflow` (true sign of the 5-bit sum) in signed mode.
  - With `b = 0`, `result = acc`, `carry = 0` and `overflow = 0`, so the shift is a plain logical or arithmetic shift.
- RUN with `cnt == 3`:
  - `product <= {msb_in, result, q[3:1]}` (the same value as the shift).
  - `state <= DONE`.
- DONE lasts one cycle:
  - Start present → accepted as above; next state RUN.
  - Otherwise → IDLE.
- `start` in RUN is ignored, not queued.
- Operands and `signed_mode` changing during RUN have no effect.
- Arithmetic:
  - Unsigned range 0..225.
  - Signed range −56..64. −8 × −8 = +64 (0x40) is representable.
  - No overflow is possible; no overflow output.
- `product` register and `product_zero` change only on the RUN→DONE edge or on reset.

## Timing
- Reset (synchronous, `rst` = 1 at an edge), output values after the edge:
  - `state` = IDLE.
  - `busy` = 0, `done` = 0.
  - `product` = 0x00, `product_zero` = 1.
  - `acc`, `q`, `m`, `cnt` = 0.
- Reset mid-RUN aborts the operation: no `done`, and `product` is cleared.
- `rst` has priority over `start`.
- Latency, with start accepted at edge E0:
  - `busy` = 1 for the cycles after E0..E3.
  - Edge E4 completes the 4th iteration.
  - `done` = 1 and the new `product` is visible in the cycle after E4.
- `busy` and `done` are never high together. `busy` is decoded from `state` (registered, glitch-free).
- Back-to-back throughput: with `start` held high, a new operation is accepted in the DONE cycle, so one result every 5 cycles.
- `start` held continuously in IDLE starts exactly one operation per acceptance; there is no edge detection requirement.

## Test plan
- Reset then idle:
  - After reset: `product` = 0x00, `product_zero` = 1, `busy` = 0, `done` = 0.
  - `start` = 0 for 10 cycles → outputs unchanged.
- Unsigned 13 × 11, `signed_mode` = 0 → `busy` 4 cycles, then `done` pulse, `product` = 0x8F (143), `product_zero` = 0. Also 15 × 15 → 0xE1.
- Signed −3 × 5 (M = 0xD, Q = 0x5, `signed_mode` = 1) → 0xF1 (−15). Signed −8 × −8 (0x8, 0x8) → 0x40 (the final step subtracts with `overflow` = 1). Signed 7 × −8 → 0xC8.
- Zero and ignore:
  - 0 × 9 → 0x00, `product_zero` = 1.
  - During RUN, toggle `start` and change operands to 15 × 15 → result still 0x00; exactly one `done` pulse.
- Back-to-back: hold `start` = 1 with 3 × 4 then 2 × 2 (unsigned). Operands switch in the DONE cycle of the first operation.
  - `done` pulses at cycles 5 and 10 after the first accept.
  - `product` shows 0x0C, then 0x04.
- Reset mid-operation: start 13 × 11, assert `rst` after the 2nd RUN cycle → next cycle `busy` = 0, `product` = 0x00, and no `done` for 10 cycles.

Source files
------------

// File: rtl/mul4_seq.sv
// Sequential 4x4 shift-and-add multiplier that shares one 4-bit add/sub unit.
// Signed mode subtracts on the final step so that the multiplier MSB weighs -8.

module add_sub_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub_or_add,
  output logic [3:0] result,
  output logic       carry,
  output logic       overflow
);

  logic [3:0] b_eff;
  logic [4:0] c;

  // Ripple-carry adder; subtraction is a + ~b + 1.
  always_comb begin
    b_eff = b ^ {4{sub_or_add}};
    c = '0;
    c[0] = sub_or_add;
    result = '0;
    for (int i = 0; i < 4; i++) begin
      result[i] = a[i] ^ b_eff[i] ^ c[i];
      c[i+1]    = (a[i] & b_eff[i]) | (a[i] & c[i]) | (b_eff[i] & c[i]);
    end
    carry    = c[4];
    overflow = c[4] ^ c[3];
  end

endmodule

module mul4_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       signed_mode,
  input  logic [3:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic       product_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_next;
  logic [3:0] acc, q, m;
  logic       sm;
  logic [1:0] cnt;
  logic       accept;
  logic       last_step;

  logic [3:0] add_b;
  logic       add_sub;
  logic [3:0] add_result;
  logic       add_carry;
  logic       add_overflow;
  logic       msb_in;
  logic [7:0] shifted;

  assign last_step = (cnt == 2'd3);
  assign add_b     = q[0] ? m : 4'b0000;
  assign add_sub   = sm & last_step & q[0];

  add_sub_4 u_add_sub (
    .a          (acc),
    .b          (add_b),
    .sub_or_add (add_sub),
    .result     (add_result),
    .carry      (add_carry),
    .overflow   (add_overflow)
  );

  // In signed mode the 5th bit is the true sign of the sum, not the carry.
  assign msb_in  = sm ? (add_result[3] ^ add_overflow) : add_carry;
  assign shifted = {msb_in, add_result, q[3:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      sm      <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      acc <= '0;
      q   <= multiplier;
      m   <= multiplicand;
      sm  <= signed_mode;
      cnt <= '0;
    end else if (state == RUN) begin
      {acc, q} <= shifted;
      cnt      <= cnt + 2'd1;
      if (last_step) product <= shifted;
    end
  end

  assign busy         = (state == RUN);
  assign done         = (state == DONE);
  assign product_zero = (product == 8'h00);

endmodule

// File: tb/tb_mul4_seq.sv
// Randomized scoreboard bench for mul4_seq: the driver pushes expected products,
// a negedge monitor pops and compares them whenever done is high.

module tb_mul4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       signed_mode;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic       product_zero;

  typedef struct {
    logic [7:0] prod;
    int         accept_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;
  int   cyc    = 0;

  mul4_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .product_zero (product_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference product from plain integer arithmetic on the operand values.
  function automatic logic [7:0] refProduct(input logic [3:0] a, input logic [3:0] b, input logic s);
    int x, y, p;
    if (s) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'(a);
      y = int'(b);
    end
    p = x * y;
    return p[7:0];
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drives a start request; returns just after the accepting edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic s);
    exp_t e;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    signed_mode  = s;
    start        = 1'b1;
    @(posedge clk);
    #1;
    e.prod       = refProduct(a, b, s);
    e.accept_cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s: done not seen within 20 cycles", name);
    end
  endtask

  task automatic runOne(input string name, input logic [3:0] a, input logic [3:0] b, input logic s);
    applyStimulus(a, b, s);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput({name, "_busy"}, {7'b0, busy}, 8'h01);
    end
    waitDone(name);
    @(negedge clk);
    checkOutput({name, "_done_drop"}, {7'b0, done}, 8'h00);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("product", product, e.prod);
        checkOutput("product_zero", {7'b0, product_zero}, {7'b0, (e.prod == 8'h00)});
        checkOutput("busy_at_done", {7'b0, busy}, 8'h00);
        checkOutput("latency", 8'(cyc - e.accept_cyc), 8'd4);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    signed_mode  = 1'b0;
    multiplicand = 4'h0;
    multiplier   = 4'h0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_product", product, 8'h00);
    checkOutput("reset_zero", {7'b0, product_zero}, 8'h01);
    checkOutput("reset_busy", {7'b0, busy}, 8'h00);
    checkOutput("reset_done", {7'b0, done}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("idle_product", product, 8'h00);
    checkOutput("idle_busy", {7'b0, busy}, 8'h00);
    checkOutput("idle_done", {7'b0, done}, 8'h00);

    runOne("u13x11", 4'd13, 4'd11, 1'b0);
    runOne("u15x15", 4'd15, 4'd15, 1'b0);
    runOne("s_m3x5", 4'hD, 4'h5, 1'b1);
    runOne("s_m8xm8", 4'h8, 4'h8, 1'b1);
    runOne("s_7xm8", 4'h7, 4'h8, 1'b1);
    runOne("u0x9", 4'd0, 4'd9, 1'b0);

    // Start toggling and operand changes during RUN must be ignored.
    applyStimulus(4'd0, 4'd9, 1'b0);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; multiplicand = 4'hF; multiplier = 4'hF; signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("ignore");
    repeat (10) @(negedge clk);
    checkOutput("ignore_hold", product, 8'h00);

    // Back-to-back with start held: second request accepted in the DONE cycle.
    applyStimulus(4'd3, 4'd4, 1'b0);
    waitDone("b2b_first");
    multiplicand = 4'd2;
    multiplier   = 4'd2;
    begin
      exp_t e;
      @(posedge clk);
      #1;
      e.prod       = refProduct(4'd2, 4'd2, 1'b0);
      e.accept_cyc = cyc;
      exp_q.push_back(e);
    end
    start = 1'b0;
    checkOutput("b2b_busy", {7'b0, busy}, 8'h01);
    waitDone("b2b_second");
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      runOne("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Reset after the second RUN cycle aborts the operation.
    applyStimulus(4'd13, 4'd11, 1'b0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    checkOutput("abort_busy", {7'b0, busy}, 8'h00);
    checkOutput("abort_product", product, 8'h00);
    checkOutput("abort_zero", {7'b0, product_zero}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", {7'b0, done}, 8'h00);
    end

    checkOutput("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
